// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: I/O window offsets and
// controller states.
package dmem_pkg;

    localparam logic [15:0] IO_OUT  = 16'd0;
    localparam logic [15:0] IO_WCNT = 16'd1;
    localparam logic [15:0] IO_DONE = 16'd2;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        HALT
    } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port RAM with write and registered read on the falling clock edge.
module dmem_ram #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(negedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory end of the CPU bus: on-chip RAM, a small I/O window, preload
// port and run/done monitor. All state updates on the falling edge of CK.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_AW     = 7,
    parameter logic [15:0] IO_BASE    = 16'hFF00,
    parameter logic [15:0] WATCH_ADDR = 16'h0000,
    parameter logic [15:0] WATCH_VAL  = 16'd45
) (
    input  logic              CK,
    input  logic              RST,
    input  logic [15:0]       DA,
    inout  logic [15:0]       DD,
    input  logic              RW,
    input  logic              LD_EN,
    input  logic [RAM_AW-1:0] LD_A,
    input  logic [15:0]       LD_D,
    output logic [15:0]       OUT,
    output logic [15:0]       WCNT,
    output logic              MATCH,
    output logic              DONE,
    output logic              ERR
);

    state_t state_q, state_d;
    logic cpu_rd, cpu_wr;
    logic in_ram, in_io;
    logic [15:0] io_off, io_val;
    logic [15:0] ram_rdata, io_q, rdata;
    logic use_ram_q;
    logic [15:0] out_q, wcnt_q;
    logic match_q, done_q, err_q;
    logic ram_we, ram_re;
    logic [RAM_AW-1:0] ram_addr;
    logic [15:0] ram_wdata;

    assign in_ram = ({1'b0, DA} < (17'd1 << RAM_AW));
    assign io_off = DA - IO_BASE;
    assign in_io  = (DA >= IO_BASE) && (io_off <= IO_DONE);

    always_ff @(negedge CK) begin
        if (RST) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    state_d = RUN;
            RUN:     if (cpu_wr && in_io && io_off == IO_DONE) state_d = HALT;
            default: state_d = state_q;
        endcase
    end

    // Reset overrides the state so CPU cycles in flight at the reset edge are dropped.
    always_comb begin
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        case (state_q)
            RUN: begin
                cpu_rd = RW;
                cpu_wr = !RW;
            end
            HALT:    cpu_rd = RW;
            default: ;
        endcase
        if (RST) begin
            cpu_rd = 1'b0;
            cpu_wr = 1'b0;
        end
    end

    always_comb begin
        case (io_off)
            IO_OUT:  io_val = out_q;
            IO_WCNT: io_val = wcnt_q;
            IO_DONE: io_val = {15'b0, done_q};
            default: io_val = '0;
        endcase
    end

    assign ram_addr  = RST ? LD_A  : DA[RAM_AW-1:0];
    assign ram_wdata = RST ? LD_D  : DD;
    assign ram_we    = RST ? LD_EN : (cpu_wr && in_ram);
    assign ram_re    = cpu_rd && in_ram;

    dmem_ram #(
        .AW(RAM_AW),
        .DW(16)
    ) u_ram (
        .clk  (CK),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(negedge CK) begin
        if (RST) begin
            io_q      <= '0;
            use_ram_q <= 1'b0;
            out_q     <= '0;
            wcnt_q    <= '0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            match_q <= cpu_wr && (in_ram || in_io) && DA == WATCH_ADDR && DD == WATCH_VAL;
            if (cpu_rd) begin
                use_ram_q <= in_ram;
                io_q      <= in_io ? io_val : '0;
                if (!in_ram && !in_io) err_q <= 1'b1;
            end
            if (cpu_wr) begin
                if (in_ram || in_io) begin
                    if (wcnt_q != '1) wcnt_q <= wcnt_q + 16'd1;
                end else begin
                    err_q <= 1'b1;
                end
                if (in_io && io_off == IO_OUT)  out_q  <= DD;
                if (in_io && io_off == IO_DONE) done_q <= 1'b1;
            end
        end
    end

    assign rdata = use_ram_q ? ram_rdata : io_q;
    assign DD    = RW ? rdata : 'z;

    assign OUT   = out_q;
    assign WCNT  = wcnt_q;
    assign MATCH = match_q;
    assign DONE  = done_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: CPU-side bus driven on the rising edge, read data
// checked against a queue of expected values one cycle later.
module tb_dmem_responder;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] val;
    } exp_t;

    logic        ck = 1'b0;
    logic        rst, rw, ld_en;
    logic [15:0] da, dd_drv, ld_d;
    logic [6:0]  ld_a;
    wire  [15:0] dd;
    logic [15:0] out_v, wcnt_v;
    logic        match_v, done_v, err_v;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   match_cnt = 0;
    logic cnt_en = 1'b0;
    logic rd_pending = 1'b0;
    exp_t exp_q[$];

    assign dd = rw ? 16'hzzzz : dd_drv;

    always #5 ck = ~ck;

    dmem_responder #(
        .RAM_AW    (7),
        .IO_BASE   (16'hFF00),
        .WATCH_ADDR(16'h0000),
        .WATCH_VAL (16'd45)
    ) dut (
        .CK   (ck),
        .RST  (rst),
        .DA   (da),
        .DD   (dd),
        .RW   (rw),
        .LD_EN(ld_en),
        .LD_A (ld_a),
        .LD_D (ld_d),
        .OUT  (out_v),
        .WCNT (wcnt_v),
        .MATCH(match_v),
        .DONE (done_v),
        .ERR  (err_v)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge ck) begin
        if (rd_pending) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("rd_%04h", e.addr), {16'h0, dd}, {16'h0, e.val});
        end
        if (cnt_en && match_v) match_cnt++;
    end

    task automatic idle();
        @(posedge ck); #1;
        rw = 1'b1; da = 16'h0000; rd_pending = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] v);
        @(posedge ck); #1;
        rw = 1'b1; da = a; rd_pending = 1'b1;
        exp_q.push_back('{addr: a, val: v});
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(posedge ck); #1;
        rw = 1'b0; da = a; dd_drv = d; rd_pending = 1'b0;
    endtask

    task automatic preload(input logic [6:0] a, input logic [15:0] d);
        @(posedge ck); #1;
        ld_en = 1'b1; ld_a = a; ld_d = d;
        @(posedge ck); #1;
        ld_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rw = 1'b1; da = '0; dd_drv = '0;
        ld_en = 1'b0; ld_a = '0; ld_d = '0;

        // preload under reset, including the last RAM word
        preload(7'd0, 16'd5);
        preload(7'd1, 16'd15);
        preload(7'd5, 16'h0055);
        preload(7'd6, 16'h0066);
        preload(7'd127, 16'hA5A5);
        idle();
        check("rst_out",   {16'h0, out_v},  0);
        check("rst_wcnt",  {16'h0, wcnt_v}, 0);
        check("rst_match", {31'h0, match_v}, 0);
        check("rst_done",  {31'h0, done_v}, 0);
        check("rst_err",   {31'h0, err_v},  0);
        check("rst_dd",    {16'h0, dd},     0);

        rst = 1'b0;
        idle();
        rd(16'h0000, 16'd5);
        rd(16'h0001, 16'd15);
        idle();
        check("load_err",  {31'h0, err_v},  0);
        check("load_wcnt", {16'h0, wcnt_v}, 0);

        // store then read back on the next cycle
        wr(16'h0003, 16'hBEEF);
        rd(16'h0003, 16'hBEEF);
        idle();
        check("st_wcnt", {16'h0, wcnt_v}, 1);

        // watched store pulses MATCH for exactly one cycle
        wr(16'h0000, 16'd45);
        idle();
        check("match_hi", {31'h0, match_v}, 1);
        idle();
        check("match_lo", {31'h0, match_v}, 0);
        rd(16'h0000, 16'd45);
        wr(16'h0000, 16'd44);
        idle();
        check("nomatch", {31'h0, match_v}, 0);
        check("wcnt3",   {16'h0, wcnt_v}, 3);
        rd(16'h0000, 16'd44);

        // I/O window and range boundaries
        wr(16'hFF00, 16'h1234);
        idle();
        check("out_reg", {16'h0, out_v}, 32'h1234);
        rd(16'hFF01, 16'd4);
        wr(16'hFF01, 16'd9);
        rd(16'hFF00, 16'h1234);
        rd(16'hFF01, 16'd5);
        rd(16'hFF02, 16'd0);
        rd(16'h007F, 16'hA5A5);
        idle();
        check("err_pre", {31'h0, err_v}, 0);
        rd(16'h0080, 16'd0);
        idle();
        check("err_set", {31'h0, err_v}, 1);
        rd(16'h0200, 16'd0);
        rd(16'hFF03, 16'd0);
        wr(16'h0100, 16'd1);
        idle();
        check("err_wr_nocount", {16'h0, wcnt_v}, 5);

        // DONE write halts; later writes ignored, reads still served
        wr(16'hFF02, 16'd1);
        idle();
        check("done_set",  {31'h0, done_v}, 1);
        check("done_wcnt", {16'h0, wcnt_v}, 6);
        wr(16'h0005, 16'd7);
        wr(16'h0000, 16'd45);
        idle();
        check("halt_match", {31'h0, match_v}, 0);
        check("halt_wcnt",  {16'h0, wcnt_v}, 6);
        rd(16'h0005, 16'h0055);
        rd(16'h0000, 16'd44);
        rd(16'hFF02, 16'd1);
        rd(16'hFF01, 16'd6);
        idle();

        // back to RUN, dirty some state, then reset during a write to RAM[6]
        rst = 1'b1;
        idle();
        rst = 1'b0;
        idle();
        wr(16'hFF00, 16'hABCD);
        rd(16'h0200, 16'd0);
        wr(16'h0000, 16'd45);
        @(posedge ck); #1;
        rst = 1'b1; rw = 1'b0; da = 16'h0006; dd_drv = 16'h0077; rd_pending = 1'b0;
        idle();
        check("mr_out",   {16'h0, out_v},  0);
        check("mr_wcnt",  {16'h0, wcnt_v}, 0);
        check("mr_done",  {31'h0, done_v}, 0);
        check("mr_err",   {31'h0, err_v},  0);
        check("mr_match", {31'h0, match_v}, 0);
        rst = 1'b0;
        idle();
        rd(16'h0006, 16'h0066);
        rd(16'h0000, 16'd45);
        rd(16'h0001, 16'd15);
        idle();

        // bus trace of the sum program: running totals, then the result store
        cnt_en = 1'b1;
        begin
            logic [15:0] acc;
            acc = '0;
            for (int i = 0; i <= 9; i++) begin
                acc = acc + 16'(i);
                wr(16'h0002, acc);
            end
        end
        wr(16'h0000, 16'd45);
        wr(16'hFF02, 16'd1);
        idle();
        idle();
        cnt_en = 1'b0;
        check("sum_match_cnt", match_cnt, 1);
        check("sum_err",  {31'h0, err_v},  0);
        check("sum_done", {31'h0, done_v}, 1);
        check("sum_wcnt", {16'h0, wcnt_v}, 12);
        rd(16'h0002, 16'd45);
        rd(16'h0000, 16'd45);
        idle();
        check("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
